multdiv_seq: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit for the CPU's MultDiv path.

---
 rtl/multdiv_seq.sv | 153 +++++++++++++++
 tb/tb_multdiv_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, WIDTH steps per op.
// Optional MULTDIV_EARLY_DIV0_EN: divide-by-zero completes on the start edge.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_en, cnt_clr, start, last, early_div0;
    logic [WIDTH:0]     acc, m, acc_nx, booth_sum, div_sh;
    logic [WIDTH-1:0]   q, q_nx, a_abs, b_abs, fin_result;
    logic               qm1, qm1_nx, neg_q, b_zero, fin_exc;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_top;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last  = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULTDIV_EARLY_DIV0_EN
    assign early_div0 = ctrl_DIV & ~ctrl_MULT & (data_operandB == '0);
`else
    assign early_div0 = 1'b0;
`endif

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == MULT) || (state == DIV);

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // A start pulse is honoured in every state and restarts the sequence.
    always_comb begin
        state_nx = state;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        if (start) begin
            cnt_clr  = 1'b1;
            state_nx = ctrl_MULT ? MULT : (early_div0 ? DONE : DIV);
        end else begin
            case (state)
                MULT, DIV: begin
                    cnt_en = 1'b1;
                    if (last) state_nx = DONE;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr)         cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_en)  cnt <= cnt + 1'b1;
    end

    always_comb begin
        a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        case ({q[0], qm1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase
        div_sh = {acc[WIDTH-1:0], q[WIDTH-1]};

        acc_nx = acc;
        q_nx   = q;
        qm1_nx = qm1;
        if (state == MULT) begin
            acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_nx   = {booth_sum[0], q[WIDTH-1:1]};
            qm1_nx = q[0];
        end else if (state == DIV) begin
            if (div_sh >= m) begin
                acc_nx = div_sh - m;
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = div_sh;
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end

        // Final value is taken from the step performed on the last edge.
        product  = {acc_nx[WIDTH-1:0], q_nx};
        prod_top = product[2*WIDTH-1:WIDTH-1];
        if (state == MULT) begin
            fin_result = product[WIDTH-1:0];
            fin_exc    = !((prod_top == '0) || (prod_top == '1));
        end else if (b_zero) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            fin_result = (neg_q && (q_nx != '0)) ? -q_nx : q_nx;
            fin_exc    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            acc            <= '0;
            m              <= '0;
            q              <= '0;
            qm1            <= 1'b0;
            neg_q          <= 1'b0;
            b_zero         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            qm1    <= 1'b0;
            neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero <= (data_operandB == '0);
            if (ctrl_MULT) begin
                m <= {data_operandA[WIDTH-1], data_operandA};
                q <= data_operandB;
            end else begin
                m <= {1'b0, b_abs};
                q <= a_abs;
            end
            if (early_div0) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
        end else if (busy) begin
            acc <= acc_nx;
            q   <= q_nx;
            qm1 <= qm1_nx;
            if (last) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq against a 64-bit arithmetic reference model.
// Honours MULTDIV_EARLY_DIV0_EN for the expected divide-by-zero latency.
module tb_multdiv_seq;
    localparam int W = 32;
`ifdef MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_LAT = 0;
`else
    localparam int DIV0_LAT = W;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          ctrl_MULT = 1'b0;
    logic          ctrl_DIV = 1'b0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;
    int            checks = 0;
    int            errors = 0;

    multdiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Reference: full-precision signed arithmetic, then truncate.
    task automatic model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
        longint p;
        logic [32:0] top;
        if (is_mult) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            top = p[63:31];
            e   = !((top == '0) || (top == '1));
        end else if (b == '0) begin
            r = '0;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
    endtask

    // Pulses a start and watches RDY for the following W+4 cycles.
    // lat = number of edges after the start edge at which RDY was first seen.
    task automatic run_op(input bit mm, input bit dd, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int pulses, output logic [W-1:0] r, output logic e);
        @(negedge clk);
        ctrl_MULT = mm; ctrl_DIV = dd; data_operandA = a; data_operandB = b;
        @(negedge clk);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        lat = -1; pulses = 0; r = '0; e = 1'b0;
        for (int j = 0; j <= W + 3; j++) begin
            if (j > 0) @(negedge clk);
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = j; r = data_result; e = data_exception;
                end
            end
        end
    endtask

    task automatic test_reset();
        int rdy_seen;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", data_result); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        // start pulse on the same edge as reset must be ignored
        ctrl_MULT = 1'b1; data_operandA = 32'd7; data_operandB = 32'd3;
        @(negedge clk);
        ctrl_MULT = 1'b0; clr = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_busy got %b exp 0", busy); end
        rdy_seen = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        checks++; if (rdy_seen != 0) begin errors++; $display("FAIL reset_wins_rdy got %0d pulses exp 0", rdy_seen); end
    endtask

    task automatic test_mult();
        logic [W-1:0] da[4] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] db[4] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] a, b, r, er;
        logic e, ee;
        int lat, pulses;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                a = da[i]; b = db[i];
            end else if (i % 2 == 0) begin
                a = $urandom; b = $urandom;
            end else begin
                a = 32'(int'($urandom_range(0, 60000)) - 30000);
                b = 32'(int'($urandom_range(0, 60000)) - 30000);
            end
            model(1'b1, a, b, er, ee);
            run_op(1'b1, 1'b0, a, b, lat, pulses, r, e);
            checks++; if (lat != W) begin errors++; $display("FAIL mult_lat a=%h b=%h got %0d exp %0d", a, b, lat, W); end
            checks++; if (pulses != 1) begin errors++; $display("FAIL mult_pulses a=%h b=%h got %0d exp 1", a, b, pulses); end
            checks++; if (r !== er) begin errors++; $display("FAIL mult_result a=%h b=%h got %h exp %h", a, b, r, er); end
            checks++; if (e !== ee) begin errors++; $display("FAIL mult_exc a=%h b=%h got %b exp %b", a, b, e, ee); end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] da[6] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C, 32'd7, 32'h8000_0000};
        logic [W-1:0] db[6] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FF9C, 32'd1};
        logic [W-1:0] a, b, r, er;
        logic e, ee;
        int lat, pulses, elat;
        for (int i = 0; i < 22; i++) begin
            if (i < 6) begin
                a = da[i]; b = db[i];
            end else if (i % 2 == 0) begin
                a = $urandom; b = $urandom >> $urandom_range(0, 31);
            end else begin
                a = 32'(int'($urandom_range(0, 20000)) - 10000);
                b = 32'(int'($urandom_range(0, 200)) - 100);
            end
            model(1'b0, a, b, er, ee);
            elat = (b == '0) ? DIV0_LAT : W;
            run_op(1'b0, 1'b1, a, b, lat, pulses, r, e);
            checks++; if (lat != elat) begin errors++; $display("FAIL div_lat a=%h b=%h got %0d exp %0d", a, b, lat, elat); end
            checks++; if (pulses != 1) begin errors++; $display("FAIL div_pulses a=%h b=%h got %0d exp 1", a, b, pulses); end
            checks++; if (r !== er) begin errors++; $display("FAIL div_result a=%h b=%h got %h exp %h", a, b, r, er); end
            checks++; if (e !== ee) begin errors++; $display("FAIL div_exc a=%h b=%h got %b exp %b", a, b, e, ee); end
        end
    endtask

    task automatic test_div0();
        logic [W-1:0] da[2] = '{32'd5, 32'hFFFF_FFFB};
        logic [W-1:0] r;
        logic e;
        int lat, pulses;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, 1'b1, da[i], 32'd0, lat, pulses, r, e);
            checks++; if (lat != DIV0_LAT) begin errors++; $display("FAIL div0_lat a=%h got %0d exp %0d", da[i], lat, DIV0_LAT); end
            checks++; if (pulses != 1) begin errors++; $display("FAIL div0_pulses a=%h got %0d exp 1", da[i], pulses); end
            checks++; if (r !== '0) begin errors++; $display("FAIL div0_result a=%h got %h exp 0", da[i], r); end
            checks++; if (e !== 1'b1) begin errors++; $display("FAIL div0_exc a=%h got %b exp 1", da[i], e); end
        end
    endtask

    task automatic test_back_to_back();
        int early_rdy, lat, pulses;
        logic [W-1:0] r;
        logic e;
        logic busy_mid;
        @(negedge clk);
        ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        early_rdy = 0; busy_mid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (j > 0) @(negedge clk);
            if (data_resultRDY === 1'b1) early_rdy++;
            if (j == 5) busy_mid = busy;
        end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_mid); end
        // second start lands 10 edges after the first
        run_op(1'b0, 1'b1, 32'd9, 32'd3, lat, pulses, r, e);
        checks++; if (early_rdy != 0) begin errors++; $display("FAIL b2b_aborted_rdy got %0d exp 0", early_rdy); end
        checks++; if (lat != W) begin errors++; $display("FAIL b2b_lat got %0d exp %0d", lat, W); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got %0d exp 1", pulses); end
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL b2b_result got %h exp 3", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL b2b_exc got %b exp 0", e); end
    endtask

    task automatic test_reset_abort();
        int lat, pulses, rdy_seen;
        logic [W-1:0] r;
        logic e;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, pulses, r, e);
        checks++; if (data_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL abort_pre_result got %h exp ffffffeb", data_result); end
        @(negedge clk);
        ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        repeat (14) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++; if (data_result !== '0) begin errors++; $display("FAIL abort_result got %h exp 0", data_result); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL abort_exc got %b exp 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL abort_rdy got %b exp 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        clr = 1'b1;
        rdy_seen = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        checks++; if (rdy_seen != 0) begin errors++; $display("FAIL abort_late_rdy got %0d exp 0", rdy_seen); end
        checks++; if (data_result !== '0) begin errors++; $display("FAIL abort_hold got %h exp 0", data_result); end
    endtask

    task automatic test_both_ctrl();
        int lat, pulses;
        logic [W-1:0] r;
        logic e;
        run_op(1'b1, 1'b1, 32'd6, 32'd3, lat, pulses, r, e);
        checks++; if (lat != W) begin errors++; $display("FAIL both_lat got %0d exp %0d", lat, W); end
        checks++; if (r !== 32'd18) begin errors++; $display("FAIL both_result got %h exp 12", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL both_exc got %b exp 0", e); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_back_to_back();
        test_reset_abort();
        test_both_ctrl();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
